// File: rtl/barrett_pkg.sv
// rtl/barrett_pkg.sv - shared parameters and shift helper for the Barrett reducer
package barrett_pkg;
    localparam int BARRETT_W     = 48;
    localparam int BARRETT_MU_W  = BARRETT_W + 5;
    localparam int BARRETT_TAG_W = 8;
    localparam int BARRETT_LAT   = 4;

    typedef enum logic {
        SHIFT_Q1,
        SHIFT_Q3
    } shift_sel_e;

    // q1 drops W-2 low bits of x; q3 drops W+5 low bits of q1*mu.
    function automatic int barrett_shift(input shift_sel_e sel, input int w);
        return (sel == SHIFT_Q1) ? (w - 2) : (w + 5);
    endfunction
endpackage

// File: rtl/barrett_reduce_pipe_if.sv
// rtl/barrett_reduce_pipe_if.sv - config, sample-in and result-out bundle of the reducer
interface barrett_reduce_pipe_if
    import barrett_pkg::*;
#(
    parameter int W     = BARRETT_W,
    parameter int MU_W  = BARRETT_MU_W,
    parameter int TAG_W = BARRETT_TAG_W
) ();
    logic              cfg_we;
    logic [W-1:0]      cfg_q;
    logic [MU_W-1:0]   cfg_mu;
    logic              cfg_ack;
    logic              in_valid;
    logic              in_ready;
    logic [2*W-1:0]    in_x;
    logic [TAG_W-1:0]  in_tag;
    logic              out_valid;
    logic              out_ready;
    logic [W-1:0]      out_r;
    logic [TAG_W-1:0]  out_tag;
    logic              idle;

    modport master (
        output cfg_we, cfg_q, cfg_mu, in_valid, in_x, in_tag, out_ready,
        input  cfg_ack, in_ready, out_valid, out_r, out_tag, idle
    );

    modport slave (
        input  cfg_we, cfg_q, cfg_mu, in_valid, in_x, in_tag, out_ready,
        output cfg_ack, in_ready, out_valid, out_r, out_tag, idle
    );
endinterface

// File: rtl/barrett_stage_reg.sv
// rtl/barrett_stage_reg.sv - data+valid pipeline register with hold enable and sync reset
module barrett_stage_reg #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          valid_in,
    input  logic [DW-1:0] data_in,
    output logic          valid_out,
    output logic [DW-1:0] data_out
);
    logic          valid_d, valid_q;
    logic [DW-1:0] data_d, data_q;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (en) begin
            valid_d = valid_in;
            data_d  = data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_out = valid_q;
    assign data_out  = data_q;
endmodule

// File: rtl/barrett_reduce_pipe.sv
// rtl/barrett_reduce_pipe.sv - four-stage Barrett reducer r = x mod q with lockstep backpressure
module barrett_reduce_pipe
    import barrett_pkg::*;
#(
    parameter int W     = BARRETT_W,
    parameter int MU_W  = BARRETT_MU_W,
    parameter int TAG_W = BARRETT_TAG_W
) (
    input  logic                  clk,
    input  logic                  rst,
    barrett_reduce_pipe_if.slave  bus
);
    localparam int SH1  = barrett_shift(SHIFT_Q1, W);
    localparam int SH3  = barrett_shift(SHIFT_Q3, W);
    localparam int Q2_W = (2 * W - SH1) + MU_W;
    localparam int Q3_W = Q2_W - SH3;
    localparam int R_W  = W + 2;
    localparam int S1_W = TAG_W + 2 * W;
    localparam int S2_W = TAG_W + R_W + Q3_W;
    localparam int S3_W = TAG_W + R_W;
    localparam int S4_W = TAG_W + W;

    logic [W-1:0]     q_d, q_q;
    logic [MU_W-1:0]  mu_d, mu_q;
    logic             cfg_ack_d, cfg_ack_q;
    logic             adv, idle, cfg_fire;

    logic             s1_v, s2_v, s3_v, s4_v;
    logic [S1_W-1:0]  s1_q;
    logic [S2_W-1:0]  s2_q;
    logic [S3_W-1:0]  s3_q;
    logic [S4_W-1:0]  s4_q;

    logic [2*W-1:0]   s1_x;
    logic [TAG_W-1:0] s1_tag, s2_tag, s3_tag;
    logic [R_W-1:0]   s2_xlo, s3_r1;
    logic [Q3_W-1:0]  s2_q3;
    logic [Q3_W-1:0]  q3;
    logic [R_W-1:0]   r1;
    logic [W-1:0]     r_fin;

    assign adv      = !s4_v || bus.out_ready;
    assign idle     = !(s1_v || s2_v || s3_v || s4_v);
    assign cfg_fire = bus.cfg_we && idle && !bus.in_valid;

    // q/mu only change when nothing is in flight, so no sample sees a mix.
    always_comb begin
        q_d       = q_q;
        mu_d      = mu_q;
        cfg_ack_d = cfg_fire;
        if (cfg_fire) begin
            q_d  = bus.cfg_q;
            mu_d = bus.cfg_mu;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q       <= '0;
            mu_q      <= '0;
            cfg_ack_q <= 1'b0;
        end else begin
            q_q       <= q_d;
            mu_q      <= mu_d;
            cfg_ack_q <= cfg_ack_d;
        end
    end

    assign {s1_tag, s1_x}         = s1_q;
    assign {s2_tag, s2_xlo, s2_q3} = s2_q;
    assign {s3_tag, s3_r1}        = s3_q;

    // Only the low W+2 bits of x - q3*q matter since the remainder is below 3q.
    always_comb begin
        q3    = Q3_W'((Q2_W'(s1_x[2*W-1:SH1]) * Q2_W'(mu_q)) >> SH3);
        r1    = s2_xlo - R_W'(s2_q3) * R_W'(q_q);
        r_fin = s3_r1[W-1:0];
        if (s3_r1 >= {1'b0, q_q, 1'b0}) begin
            r_fin = W'(s3_r1 - {1'b0, q_q, 1'b0});
        end else if (s3_r1 >= {2'b00, q_q}) begin
            r_fin = W'(s3_r1 - {2'b00, q_q});
        end
    end

    barrett_stage_reg #(.DW(S1_W)) u_s1 (
        .clk(clk), .rst(rst), .en(adv),
        .valid_in(bus.in_valid), .data_in({bus.in_tag, bus.in_x}),
        .valid_out(s1_v), .data_out(s1_q)
    );

    barrett_stage_reg #(.DW(S2_W)) u_s2 (
        .clk(clk), .rst(rst), .en(adv),
        .valid_in(s1_v), .data_in({s1_tag, s1_x[R_W-1:0], q3}),
        .valid_out(s2_v), .data_out(s2_q)
    );

    barrett_stage_reg #(.DW(S3_W)) u_s3 (
        .clk(clk), .rst(rst), .en(adv),
        .valid_in(s2_v), .data_in({s2_tag, r1}),
        .valid_out(s3_v), .data_out(s3_q)
    );

    barrett_stage_reg #(.DW(S4_W)) u_s4 (
        .clk(clk), .rst(rst), .en(adv),
        .valid_in(s3_v), .data_in({s3_tag, r_fin}),
        .valid_out(s4_v), .data_out(s4_q)
    );

    assign bus.in_ready             = adv;
    assign bus.out_valid            = s4_v;
    assign {bus.out_tag, bus.out_r} = s4_q;
    assign bus.cfg_ack              = cfg_ack_q;
    assign bus.idle                 = idle;
endmodule

// File: tb/tb_barrett_reduce_pipe.sv
// tb/tb_barrett_reduce_pipe.sv - randomized scoreboard bench for barrett_reduce_pipe
module tb_barrett_reduce_pipe;
    localparam int W     = 13;
    localparam int MU_W  = W + 5;
    localparam int TAG_W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    barrett_reduce_pipe_if #(.W(W), .MU_W(MU_W), .TAG_W(TAG_W)) bus ();
    barrett_reduce_pipe #(.W(W), .MU_W(MU_W), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    typedef struct {
        longint           r;
        logic [TAG_W-1:0] tag;
        int               acc_cyc;
    } exp_t;

    exp_t             exp_q[$];
    exp_t             e_mon;
    int               total = 0;
    int               bad = 0;
    int               cyc = 0;
    int               mq = 0;
    bit               lat_chk = 0;
    bit               rand_ready = 0;
    bit               hold_prev = 0;
    logic [W-1:0]     r_prev;
    logic [TAG_W-1:0] tag_prev;
    int               qs[3] = '{3329, 7681, 7937};

    task automatic check_eq(input string tag, input longint got, input longint exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            hold_prev = 0;
        end else begin
            check_eq("in_ready", bus.in_ready, (!bus.out_valid || bus.out_ready));
            if (hold_prev) begin
                check_eq("hold_valid", bus.out_valid, 1);
                check_eq("hold_r", bus.out_r, r_prev);
                check_eq("hold_tag", bus.out_tag, tag_prev);
            end
            if (bus.in_valid && bus.in_ready) begin
                e_mon.r       = (mq != 0) ? (longint'(bus.in_x) % mq) : 0;
                e_mon.tag     = bus.in_tag;
                e_mon.acc_cyc = cyc;
                exp_q.push_back(e_mon);
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    check_eq("spurious_out", 1, 0);
                end else begin
                    e_mon = exp_q.pop_front();
                    check_eq("out_r", bus.out_r, e_mon.r);
                    check_eq("out_tag", bus.out_tag, e_mon.tag);
                    check_eq("r_lt_q", (bus.out_r < mq), 1);
                    if (lat_chk) check_eq("latency", cyc - e_mon.acc_cyc, 4);
                end
            end
            hold_prev = bus.out_valid && !bus.out_ready;
            r_prev    = bus.out_r;
            tag_prev  = bus.out_tag;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready) begin
            bus.out_ready = ($urandom_range(3, 0) != 0);
            #1;
        end
    endtask

    task automatic send(input logic [2*W-1:0] x, input logic [TAG_W-1:0] tag);
        bit done = 0;
        bus.in_valid = 1'b1;
        bus.in_x     = x;
        bus.in_tag   = tag;
        for (int n = 0; n < 200 && !done; n++) begin
            done = bus.in_ready;
            tick();
        end
        bus.in_valid = 1'b0;
        if (!done) check_eq("send_timeout", 0, 1);
    endtask

    task automatic do_cfg(input int q, input bit exp_ack);
        bus.cfg_we = 1'b1;
        bus.cfg_q  = W'(q);
        bus.cfg_mu = MU_W'((64'd1 << (2 * W + 3)) / q);
        tick();
        bus.cfg_we = 1'b0;
        check_eq("cfg_ack", bus.cfg_ack, exp_ack);
        if (exp_ack) mq = q;
        tick();
        check_eq("cfg_ack_pulse", bus.cfg_ack, 0);
    endtask

    task automatic drain();
        int n = 0;
        rand_ready    = 0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        while (!bus.idle && n < 50) begin
            tick();
            n++;
        end
        check_eq("drain_idle", bus.idle, 1);
        check_eq("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        logic [2*W-1:0] dir_x[5] = '{0, 3329, 3330, 6657, 11075583};
        int q;
        bus.cfg_we = 0; bus.cfg_q = 0; bus.cfg_mu = 0;
        bus.in_valid = 0; bus.in_x = 0; bus.in_tag = 0;
        bus.out_ready = 1;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        check_eq("rst_out_valid", bus.out_valid, 0);
        check_eq("rst_out_r", bus.out_r, 0);
        check_eq("rst_out_tag", bus.out_tag, 0);
        check_eq("rst_cfg_ack", bus.cfg_ack, 0);
        check_eq("rst_idle", bus.idle, 1);
        check_eq("rst_in_ready", bus.in_ready, 1);

        do_cfg(3329, 1);
        lat_chk = 1;
        send(26'd11075584, 8'h5a);
        drain();

        for (int i = 0; i < 5; i++) send(dir_x[i], 8'(i + 16));
        drain();
        lat_chk = 0;

        for (int i = 0; i < 10; i++) begin
            logic [2*W-1:0] x = 26'($urandom_range(3329 * 3329 - 1, 0));
            if (i == 5) begin
                bus.out_ready = 1'b0;
                bus.in_valid  = 1'b1;
                bus.in_x      = x;
                bus.in_tag    = 8'(i + 32);
                #1;
                for (int k = 0; k < 3; k++) begin
                    check_eq("bp_in_ready", bus.in_ready, 0);
                    tick();
                end
                bus.out_ready = 1'b1;
            end
            send(x, 8'(i + 32));
        end
        drain();

        send(26'd100000, 8'h41);
        send(26'd200000, 8'h42);
        do_cfg(7681, 0);
        drain();
        do_cfg(7681, 1);
        for (int i = 0; i < 4; i++) send(26'($urandom_range(7681 * 7681 - 1, 0)), 8'(i + 48));
        drain();
        bus.in_valid = 1'b1; bus.in_x = 26'd5000000; bus.in_tag = 8'h77;
        bus.cfg_we = 1'b1; bus.cfg_q = W'(3329); bus.cfg_mu = MU_W'((64'd1 << (2 * W + 3)) / 3329);
        tick();
        bus.in_valid = 1'b0; bus.cfg_we = 1'b0;
        check_eq("cfg_vs_input_ack", bus.cfg_ack, 0);
        drain();

        do_cfg(3329, 1);
        for (int i = 0; i < 3; i++) send(26'($urandom_range(3329 * 3329 - 1, 0)), 8'(i + 64));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        mq  = 0;
        check_eq("post_rst_valid", bus.out_valid, 0);
        check_eq("post_rst_idle", bus.idle, 1);
        for (int i = 0; i < 8; i++) begin
            tick();
            check_eq("post_rst_quiet", bus.out_valid, 0);
        end

        for (int qi = 0; qi < 3; qi++) begin
            q = qs[qi];
            drain();
            do_cfg(q, 1);
            rand_ready = 1;
            for (int i = 0; i < 3334; i++) begin
                while ($urandom_range(2, 0) == 0) tick();
                send(26'($urandom_range(q * q - 1, 0)), 8'($urandom));
            end
        end
        drain();

        check_eq("final_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
